// File: rtl/motor_pid_pkg.sv
// Shared types, register map, datapath widths and the saturation helper
// for the motor position PID sequencer.
package motor_pid_pkg;

  localparam int E_W     = 16;
  localparam int I_W     = 24;
  localparam int ACC_W   = 42;
  localparam int CMD_MAX = 2047;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_WAIT   = 3'd1;
  localparam state_t ST_SAMPLE = 3'd2;
  localparam state_t ST_ERR    = 3'd3;
  localparam state_t ST_MUL_P  = 3'd4;
  localparam state_t ST_MUL_I  = 3'd5;
  localparam state_t ST_MUL_D  = 3'd6;
  localparam state_t ST_OUT    = 3'd7;

  localparam logic [2:0] ADDR_CTRL       = 3'd0;
  localparam logic [2:0] ADDR_SETPOINT   = 3'd1;
  localparam logic [2:0] ADDR_KP         = 3'd2;
  localparam logic [2:0] ADDR_KI         = 3'd3;
  localparam logic [2:0] ADDR_KD         = 3'd4;
  localparam logic [2:0] ADDR_SAMPLE_DIV = 3'd5;
  localparam logic [2:0] ADDR_LAST_CMD   = 3'd6;
  localparam logic [2:0] ADDR_STATUS     = 3'd7;

  localparam logic signed [63:0] E_MAX   = 64'sd32767;
  localparam logic signed [63:0] E_MIN   = -64'sd32768;
  localparam logic signed [63:0] I_LIM   = 64'sd8388607;
  localparam logic signed [63:0] CMD_LIM = 64'(CMD_MAX);

  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input logic signed [63:0] lo,
    input logic signed [63:0] hi
  );
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pid_mac.sv
// Time-shared signed multiply-accumulate. acc shows the running sum including
// the product presented this cycle, so the scheduler can use it without a bubble.
module pid_mac
  import motor_pid_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [I_W-1:0]   a,
  input  logic signed [E_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [I_W+E_W-1:0] prod;
  logic signed [ACC_W-1:0]   base;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;

  always_comb begin
    prod  = a * b;
    base  = clr ? '0 : acc_q;
    acc_d = acc_q;
    if (en) acc_d = base + ACC_W'(prod);
  end

  assign acc = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/motor_pid_sequencer.sv
// Sample-period PID position loop: register file, tick counter, scheduler FSM
// driving the shared MAC, and saturated signed duty-command output.
module motor_pid_sequencer
  import motor_pid_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV_RST = 50000,
  parameter int unsigned GAIN_FRAC      = 8
) (
  input  logic        clk_clk,
  input  logic        rst_reset_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic [31:0] pos_in,
  output logic        cmd_write,
  output logic [31:0] cmd_writedata
);

  logic enable_q, enable_d, overrun_q, overrun_d, clr_int;
  logic [31:0] setpoint_q, setpoint_d, sample_div_q, sample_div_d;
  logic [15:0] kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic [31:0] last_cmd_q, last_cmd_d, cmd_data_q, cmd_data_d;
  logic        cmd_write_q, cmd_write_d, stop_pend_q, stop_pend_d;
  state_t      state_q, state_d;
  logic [31:0] tick_cnt_q, tick_cnt_d, div_eff, pos_q, pos_d, rdata;
  logic        tick, abort;
  logic signed [E_W-1:0] e_q, e_d, d_q, d_d, e_prev_q, e_prev_d, e_new, d_new;
  logic signed [I_W-1:0] integ_q, integ_d, i_new;
  logic signed [63:0]    err_full, dif_full, int_full;
  logic                  mac_clr, mac_en;
  logic signed [I_W-1:0] mac_a;
  logic signed [E_W-1:0] mac_b;
  logic signed [ACC_W-1:0] mac_acc, acc_sh;
  logic [31:0] cmd_u;

  assign div_eff = (sample_div_q == 32'd0) ? 32'd1 : sample_div_q;
  assign tick    = enable_q && (tick_cnt_q >= div_eff - 32'd1);

  assign err_full = 64'($signed(setpoint_q)) - 64'($signed(pos_q));
  assign e_new    = E_W'(saturate(err_full, E_MIN, E_MAX));
  assign dif_full = 64'(e_new) - 64'(e_prev_q);
  assign d_new    = E_W'(saturate(dif_full, E_MIN, E_MAX));
  assign int_full = 64'(integ_q) + 64'(e_new);
  assign i_new    = I_W'(saturate(int_full, -I_LIM, I_LIM));

  // The command leaves in the OUT cycle, so it is taken from the MAC sum as the D term lands.
  assign acc_sh = mac_acc >>> GAIN_FRAC;
  assign cmd_u  = 32'(saturate(64'(acc_sh), -CMD_LIM, CMD_LIM));

  always_comb begin
    enable_d     = enable_q;
    overrun_d    = overrun_q;
    setpoint_d   = setpoint_q;
    kp_d         = kp_q;
    ki_d         = ki_q;
    kd_d         = kd_q;
    sample_div_d = sample_div_q;
    clr_int      = 1'b0;
    if (avs_write) begin
      case (avs_address)
        ADDR_CTRL: begin
          enable_d = avs_writedata[0];
          clr_int  = avs_writedata[1];
          if (avs_writedata[2]) overrun_d = 1'b0;
        end
        ADDR_SETPOINT:   setpoint_d   = avs_writedata;
        ADDR_KP:         kp_d         = avs_writedata[15:0];
        ADDR_KI:         ki_d         = avs_writedata[15:0];
        ADDR_KD:         kd_d         = avs_writedata[15:0];
        ADDR_SAMPLE_DIV: sample_div_d = avs_writedata;
        default: ;
      endcase
    end
    if (tick && state_q != ST_WAIT) overrun_d = 1'b1;
    if (!enable_q || tick) tick_cnt_d = 32'd0;
    else                   tick_cnt_d = tick_cnt_q + 32'd1;
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    e_d         = e_q;
    d_d         = d_q;
    e_prev_d    = e_prev_q;
    integ_d     = integ_q;
    cmd_write_d = 1'b0;
    cmd_data_d  = cmd_data_q;
    last_cmd_d  = last_cmd_q;
    stop_pend_d = stop_pend_q;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    mac_a       = '0;
    mac_b       = '0;
    abort       = (state_q != ST_IDLE) && !enable_d;
    case (state_q)
      ST_IDLE:   if (enable_q) state_d = ST_WAIT;
      ST_WAIT:   if (tick) state_d = ST_SAMPLE;
      ST_SAMPLE: begin
        pos_d   = pos_in;
        state_d = ST_ERR;
      end
      ST_ERR: begin
        e_d      = e_new;
        d_d      = d_new;
        integ_d  = i_new;
        e_prev_d = e_new;
        state_d  = ST_MUL_P;
      end
      ST_MUL_P: begin
        mac_clr = 1'b1;
        mac_en  = 1'b1;
        mac_a   = I_W'(e_q);
        mac_b   = $signed(kp_q);
        state_d = ST_MUL_I;
      end
      ST_MUL_I: begin
        mac_en  = 1'b1;
        mac_a   = integ_q;
        mac_b   = $signed(ki_q);
        state_d = ST_MUL_D;
      end
      ST_MUL_D: begin
        mac_en  = 1'b1;
        mac_a   = I_W'(d_q);
        mac_b   = $signed(kd_q);
        state_d = ST_OUT;
        if (!abort) begin
          cmd_write_d = 1'b1;
          cmd_data_d  = cmd_u;
          last_cmd_d  = cmd_u;
        end
      end
      default:   state_d = ST_WAIT;
    endcase
    if (abort) state_d = ST_IDLE;
    // A stop requested while a command is on the bus is deferred one cycle.
    if (abort || stop_pend_q) begin
      if (cmd_write_q) begin
        stop_pend_d = 1'b1;
      end else begin
        stop_pend_d = 1'b0;
        cmd_write_d = 1'b1;
        cmd_data_d  = 32'd0;
      end
    end
    if (clr_int) begin
      integ_d  = '0;
      e_prev_d = '0;
    end
  end

  pid_mac u_mac (
    .clk   (clk_clk),
    .rst_n (rst_reset_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (mac_a),
    .b     (mac_b),
    .acc   (mac_acc)
  );

  always_comb begin
    rdata = '0;
    case (avs_address)
      ADDR_CTRL:       rdata = {29'd0, overrun_q, 1'b0, enable_q};
      ADDR_SETPOINT:   rdata = setpoint_q;
      ADDR_KP:         rdata = {{16{kp_q[15]}}, kp_q};
      ADDR_KI:         rdata = {{16{ki_q[15]}}, ki_q};
      ADDR_KD:         rdata = {{16{kd_q[15]}}, kd_q};
      ADDR_SAMPLE_DIV: rdata = sample_div_q;
      ADDR_LAST_CMD:   rdata = last_cmd_q;
      default:         rdata = {integ_q, 5'd0, state_q};
    endcase
    avs_readdata = avs_read ? rdata : 32'd0;
  end

  assign cmd_write     = cmd_write_q;
  assign cmd_writedata = cmd_data_q;

  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      enable_q     <= 1'b0;
      overrun_q    <= 1'b0;
      setpoint_q   <= '0;
      kp_q         <= '0;
      ki_q         <= '0;
      kd_q         <= '0;
      sample_div_q <= 32'(SAMPLE_DIV_RST);
      last_cmd_q   <= '0;
      cmd_data_q   <= '0;
      cmd_write_q  <= 1'b0;
      stop_pend_q  <= 1'b0;
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      pos_q        <= '0;
      e_q          <= '0;
      d_q          <= '0;
      e_prev_q     <= '0;
      integ_q      <= '0;
    end else begin
      enable_q     <= enable_d;
      overrun_q    <= overrun_d;
      setpoint_q   <= setpoint_d;
      kp_q         <= kp_d;
      ki_q         <= ki_d;
      kd_q         <= kd_d;
      sample_div_q <= sample_div_d;
      last_cmd_q   <= last_cmd_d;
      cmd_data_q   <= cmd_data_d;
      cmd_write_q  <= cmd_write_d;
      stop_pend_q  <= stop_pend_d;
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      pos_q        <= pos_d;
      e_q          <= e_d;
      d_q          <= d_d;
      e_prev_q     <= e_prev_d;
      integ_q      <= integ_d;
    end
  end

endmodule

// File: tb/tb_motor_pid_sequencer.sv
// Directed and randomized checks of motor_pid_sequencer against a plain-arithmetic
// PID reference model; inputs are driven and outputs sampled on the falling edge.
module tb_motor_pid_sequencer;
  import motor_pid_pkg::*;

  logic        clk_clk = 1'b0;
  logic        rst_reset_n = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic [31:0] pos_in = '0;
  logic        cmd_write;
  logic [31:0] cmd_writedata;

  motor_pid_sequencer dut (
    .clk_clk       (clk_clk),
    .rst_reset_n   (rst_reset_n),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .pos_in        (pos_in),
    .cmd_write     (cmd_write),
    .cmd_writedata (cmd_writedata)
  );

  // clock / reset
  always #10 clk_clk = ~clk_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk_clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // no two back-to-back command strobes
  logic prev_cw = 1'b0;
  always @(negedge clk_clk) begin
    if (rst_reset_n && cmd_write === 1'b1) check("cmd_gap", {31'd0, prev_cw}, 32'd0);
    prev_cw = rst_reset_n ? cmd_write : 1'b0;
  end

  // driver tasks (called just after a falling edge)
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk_clk);
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    #1;
    d           = avs_readdata;
    avs_read    = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_cmd(output logic [31:0] d, output int c, input int budget);
    logic got;
    got = 1'b0;
    d   = '0;
    c   = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_clk);
      if (cmd_write === 1'b1) begin
        got = 1'b1;
        d   = cmd_writedata;
        c   = cyc;
        break;
      end
    end
    check("cmd_arrives", {31'd0, got}, 32'd1);
  endtask

  // reference model: one PID sample computed from the loop definition
  longint b_sp = 0, b_pos = 0, b_kp = 0, b_ki = 0, b_kd = 0;
  longint m_int = 0, m_eprev = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = '0;

  function automatic longint clip(input longint v, input longint lo, input longint hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic model_sample();
    longint e, d, acc, q;
    e       = clip(b_sp - b_pos, -32768, 32767);
    d       = clip(e - m_eprev, -32768, 32767);
    m_int   = clip(m_int + e, -8388607, 8388607);
    m_eprev = e;
    acc     = b_kp * e + b_ki * m_int + b_kd * d;
    q       = (acc >= 0) ? acc / 256 : -((-acc + 255) / 256);
    exp_q.push_back(32'(clip(q, -2047, 2047)));
  endtask

  task automatic model_clr();
    m_int   = 0;
    m_eprev = 0;
  endtask

  // scoreboard: one model sample per observed command
  task automatic score_cmd(input string tag, output logic [31:0] d, output int c);
    logic [31:0] exp;
    model_sample();
    wait_cmd(d, c, 200);
    exp      = exp_q.pop_front();
    last_exp = exp;
    check(tag, d, exp);
  endtask

  task automatic write_cfg(input logic clr);
    wr(ADDR_KP, 32'(b_kp));
    wr(ADDR_KI, 32'(b_ki));
    wr(ADDR_KD, 32'(b_kd));
    wr(ADDR_SETPOINT, 32'(b_sp));
    pos_in = 32'(b_pos);
    if (clr) begin
      wr(ADDR_CTRL, 32'h3);
      model_clr();
    end
  endtask

  task automatic reset_regs_check(input string tag);
    check({tag, "_cw"}, {31'd0, cmd_write}, 32'd0);
    check({tag, "_cwd"}, cmd_writedata, 32'd0);
    check_rd({tag, "_ctrl"}, ADDR_CTRL, 32'd0);
    check_rd({tag, "_status"}, ADDR_STATUS, 32'd0);
    check_rd({tag, "_div"}, ADDR_SAMPLE_DIV, 32'd50000);
    check_rd({tag, "_kp"}, ADDR_KP, 32'd0);
    check_rd({tag, "_sp"}, ADDR_SETPOINT, 32'd0);
    check_rd({tag, "_last"}, ADDR_LAST_CMD, 32'd0);
  endtask

  initial begin
    logic [31:0] d, d2;
    int c, c1, c2, e_cyc;
    logic found;

    repeat (3) @(negedge clk_clk);
    rst_reset_n = 1'b1;
    @(negedge clk_clk);
    reset_regs_check("rst0");

    // P only: first command after (div-1) counts to the tick plus six cycles
    b_kp = 256; b_sp = 100; b_pos = 0;
    wr(ADDR_SAMPLE_DIV, 32'd20);
    write_cfg(1'b0);
    e_cyc = cyc + 1;
    wr(ADDR_CTRL, 32'h1);
    score_cmd("p_cmd1", d, c1);
    check("p_val1", d, 32'd100);
    check("p_latency", 32'(c1 - e_cyc), 32'((20 - 1) + 6));
    score_cmd("p_cmd2", d, c2);
    check("p_period", 32'(c2 - c1), 32'd20);
    check_rd("p_last", ADDR_LAST_CMD, 32'd100);

    // saturation both ways
    b_sp = 5000;  write_cfg(1'b0);
    score_cmd("sat_pos", d, c);
    check("sat_pos_val", d, 32'h000007FF);
    b_sp = -5000; write_cfg(1'b0);
    score_cmd("sat_neg", d, c);
    check("sat_neg_val", d, 32'hFFFFF801);

    // integral
    b_kp = 0; b_ki = 256; b_kd = 0; b_sp = 10; b_pos = 0;
    write_cfg(1'b1);
    score_cmd("int_1", d, c);  check("int_1_val", d, 32'd10);
    score_cmd("int_2", d, c);  check("int_2_val", d, 32'd20);
    score_cmd("int_3", d, c);  check("int_3_val", d, 32'd30);
    wr(ADDR_CTRL, 32'h3); model_clr();
    score_cmd("int_clr", d, c); check("int_clr_val", d, 32'd10);

    // derivative
    b_ki = 0; b_kd = 256; b_sp = 0; b_pos = 0;
    write_cfg(1'b1);
    score_cmd("der_1", d, c);  check("der_1_val", d, 32'd0);
    b_pos = -50; pos_in = 32'(b_pos);
    score_cmd("der_2", d, c);  check("der_2_val", d, 32'd50);
    score_cmd("der_3", d, c);  check("der_3_val", d, 32'd0);

    // randomized gains, setpoint and position
    for (int i = 0; i < 14; i++) begin
      b_kp  = longint'($urandom_range(0, 1024)) - 512;
      b_ki  = longint'($urandom_range(0, 512)) - 256;
      b_kd  = longint'($urandom_range(0, 1024)) - 512;
      b_sp  = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 200000)) - 100000
                                          : longint'($urandom_range(0, 8000)) - 4000;
      b_pos = longint'($urandom_range(0, 8000)) - 4000;
      write_cfg($urandom_range(0, 3) == 0);
      score_cmd("rand_cmd", d, c);
    end

    // overrun with a too-short period; zero error keeps the model steady
    b_kp = 0; b_kd = 0; b_ki = 256; b_sp = 0; b_pos = 0;
    write_cfg(1'b0);
    score_cmd("ovr_pre", d, c);
    wr(ADDR_SAMPLE_DIV, 32'd3);
    score_cmd("ovr_cmd1", d, c1);
    score_cmd("ovr_cmd2", d, c2);
    check("ovr_interval_ge7", {31'd0, (c2 - c1) >= 7}, 32'd1);
    check_rd("ovr_ctrl", ADDR_CTRL, 32'h5);

    // disable while in MUL_I
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_clk);
      rd(ADDR_STATUS, d);
      if (d[2:0] == ST_MUL_I) begin
        found = 1'b1;
        break;
      end
    end
    check("dis_found_mul_i", {31'd0, found}, 32'd1);
    model_sample();
    void'(exp_q.pop_back());
    wr(ADDR_CTRL, 32'h0);
    check("dis_stop_cw", {31'd0, cmd_write}, 32'd1);
    check("dis_stop_val", cmd_writedata, 32'd0);
    rd(ADDR_STATUS, d2);
    check("dis_state_idle", {29'd0, d2[2:0]}, 32'(ST_IDLE));
    check("dis_integ_kept", {8'd0, d2[31:8]}, {8'd0, 24'(m_int)});
    check_rd("dis_last", ADDR_LAST_CMD, last_exp);
    @(negedge clk_clk);
    check("dis_single_stop", {31'd0, cmd_write}, 32'd0);
    wr(ADDR_CTRL, 32'h4);
    check_rd("ovr_cleared", ADDR_CTRL, 32'd0);

    // reset while a command strobe is high
    wr(ADDR_SAMPLE_DIV, 32'd20);
    wr(ADDR_CTRL, 32'h1);
    wait_cmd(d, c, 200);
    rst_reset_n = 1'b0;
    #1;
    check("rst_async_cw", {31'd0, cmd_write}, 32'd0);
    @(negedge clk_clk);
    rst_reset_n = 1'b1;
    model_clr();

    // reset in MUL_P
    wr(ADDR_KP, 32'h100);
    wr(ADDR_SETPOINT, 32'd50);
    wr(ADDR_SAMPLE_DIV, 32'd10);
    wr(ADDR_CTRL, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_clk);
      rd(ADDR_STATUS, d);
      if (d[2:0] == ST_MUL_P) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_found_mul_p", {31'd0, found}, 32'd1);
    rst_reset_n = 1'b0;
    #1;
    reset_regs_check("rst_mulp");
    @(negedge clk_clk);
    rst_reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_pid_sequencer.md
# motor_pid_sequencer

Closed-loop position controller that sits on the Avalon fabric between software and the motor PWM/encoder block. Each sample period it reads the encoder position count, computes a PID correction against a software-written setpoint, and issues one signed duty-cycle write in the motor block's format: bit 11 is the sign, magnitude is 0–2047. One signed multiplier is time-shared across the P, I and D terms by an internal scheduler FSM. Software configures gains and period through a small register file.

## Interface
- SAMPLE_DIV_RST, 50000, reset value of the sample-period register in clk cycles (1 kHz at 50 MHz)
- GAIN_FRAC, 8, fractional bits of the Q8.8 gains
- clk_clk  in  1  system clock, 50 MHz
- rst_reset_n  in  1  reset; asynchronous assert, active-low
- avs_address  in  3  register select
- avs_write  in  1  register write strobe
- avs_writedata  in  32  register write data
- avs_read  in  1  register read strobe
- avs_readdata  out  32  register read data; combinational, zero wait states
- pos_in  in  32  signed encoder position count, synchronous to clk_clk
- cmd_write  out  1  one-cycle strobe to the motor block write port
- cmd_writedata  out  32  signed duty command, sign-extended, range ±2047

## Operation
- Registers:
  - 0 CTRL: bit0 enable, bit1 clr_int (self-clearing), bit2 overrun (sticky; write 1 to clear).
  - 1 SETPOINT: s32.
  - 2 KP, 3 KI, 4 KD: s16 Q8.8, in bits [15:0].
  - 5 SAMPLE_DIV: u32; a value of 0 is treated as 1.
  - 6 LAST_CMD: read-only, sign-extended.
  - 7 STATUS: read-only; [2:0] FSM state, [31:8] integrator.
- Tick counter:
  - Counts while enable=1. Emits `tick` and reloads when it reaches SAMPLE_DIV-1.
  - Held at 0 while enable=0.
- FSM states: IDLE, WAIT, SAMPLE, ERR, MUL_P, MUL_I, MUL_D, OUT.
  - IDLE→WAIT when enable=1.
  - WAIT→SAMPLE on tick.
  - SAMPLE→ERR→MUL_P→MUL_I→MUL_D→OUT→WAIT, one cycle per state.
- SAMPLE: latch pos_in.
- ERR:
  - e = SETPOINT − pos, saturated to s16.
  - d = e − e_prev, saturated to s16.
  - I = I + e, saturated to ±(2^23−1).
  - e_prev ← e.
- MUL_P/I/D: the shared multiplier computes s24 × s16 → s40 and accumulates into s42 acc.
  - MUL_P clears acc before accumulating KP·e.
  - MUL_I adds KI·I; MUL_D adds KD·d.
- OUT:
  - u = acc >>> GAIN_FRAC (arithmetic shift), saturated to [−2047, +2047]. −2048 is never produced.
  - cmd_writedata ← u; cmd_write ← 1 for exactly one cycle; LAST_CMD ← u.
- Overrun: a tick arriving in any state other than WAIT sets overrun and is dropped. The sequence in flight completes unchanged.
- Disable (enable written 0) in any non-IDLE state:
  - Abort to IDLE on the next cycle.
  - Emit one cmd_write with cmd_writedata=0 to stop the motor.
  - Integrator and e_prev are preserved.
- clr_int: zeroes I and e_prev on the cycle after the write. If this coincides with ERR, the clear wins.
- Gain or setpoint writes take effect at the next state that uses them; there is no shadowing.

## Timing
- Reset values:
  - cmd_write=0, cmd_writedata=0, avs_readdata reflects reset registers.
  - enable=0, gains=0, SETPOINT=0, SAMPLE_DIV=SAMPLE_DIV_RST.
  - I=0, e_prev=0, state=IDLE, overrun=0.
- Latency:
  - tick → cmd_write is 6 cycles: tick in WAIT; SAMPLE, ERR, MUL_P, MUL_I, MUL_D, then OUT registers cmd_write.
  - pos_in is sampled on the cycle after tick.
- Minimum sustainable SAMPLE_DIV is 7. Below 7, ticks overrun and outputs occur every 7 cycles or slower.
- cmd_write is never asserted on two consecutive cycles.
- Reset assertion mid-sequence: all state clears immediately; cmd_write deasserts asynchronously.
- A simultaneous avs_write and avs_read to the same register returns the old value.

## Structure
- Package motor_pid_pkg holds:
  - state enum;
  - register address constants;
  - widths: E_W=16, I_W=24, ACC_W=42, CMD_MAX=2047;
  - saturate function.
- Sub-module pid_mac: shared signed multiplier plus accumulator, with inputs clr, en, a[23:0], b[15:0] and output acc[41:0]. The scheduler FSM drives its operand muxes.
- Top level contains the register file, tick counter, FSM and output saturation.

## Test plan
- P only: KP=0x0100, SETPOINT=100, pos_in=0, SAMPLE_DIV=20, enable → cmd_writedata=100 six cycles after the first tick, repeating every 20 cycles.
- Saturation: KP=0x0100, SETPOINT=5000 → 2047 (0x000007FF). SETPOINT=−5000 → −2047 (0xFFFFF801).
- Integral: KI=0x0100, KP=KD=0, constant e=10 → successive commands 10, 20, 30. Writing clr_int → next command 10.
- Derivative: KD=0x0100, pos_in steps 0→−50 between samples with SETPOINT=0 → commands 0, then 50, then 0.
- Overrun and disable: SAMPLE_DIV=3 → overrun bit reads 1. Clearing enable mid-MUL_I → IDLE next cycle and one cmd_write with 0.
- Reset: deassert rst_reset_n mid-MUL_P → cmd_write=0, STATUS=0, all registers at reset values.
